// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
//
// Adds two W-bit unsigned operands plus a carry-in one bit at a time. It uses
// an external, clocked single-bit full-adder stage whose Sum/Carry_out return
// exactly ADD_LAT cycles after the bit pulse that produced them. Bit k is
// issued as a one-cycle pulse on fa_a/fa_b/fa_cin. Its result is captured
// ADD_LAT cycles later, so each bit takes ADD_LAT+1 cycles. The returned
// carry feeds the next bit's pulse directly.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand request handshake (ready only in IDLE)
//   in_a, in_b, in_cin  operands and initial carry, latched on accept
//   fa_a, fa_b, fa_cin  registered bit pulses to the full-adder stage
//   fa_sum, fa_cout     full-adder stage results (sampled only on capture)
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_sum, out_cout   assembled sum and final carry
//   busy                high in every state except IDLE

module serial_add_sequencer #(
    parameter int W       = 8,
    parameter int ADD_LAT = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    input  logic         fa_sum,
    input  logic         fa_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int KW = $clog2(W);
    localparam int CW = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   k;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            accept;
    logic            capture;
    logic            last_bit;

    always_comb begin
        accept   = (state == IDLE) && in_valid;
        // The WAIT stretch lasts ADD_LAT cycles after the pulse cycle. Its
        // last cycle is the one where the adder result is on fa_sum/fa_cout.
        capture  = (state == WAIT) && (cnt == CW'(ADD_LAT - 1));
        last_bit = (k == KW'(W - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = last_bit ? DONE : ISSUE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // The pulse registers are loaded on the edge that enters ISSUE, so they
    // are high exactly during the ISSUE cycle and zero everywhere else. The
    // operands are shifted right after each capture, so the next bit to
    // issue is always bit 1 of the shift registers at that point.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            fa_a     <= 1'b0;
            fa_b     <= 1'b0;
            fa_cin   <= 1'b0;
        end else begin
            state  <= state_nxt;
            fa_a   <= 1'b0;
            fa_b   <= 1'b0;
            fa_cin <= 1'b0;

            if ((state == WAIT) && !capture) cnt <= cnt + 1'b1;
            else                             cnt <= '0;

            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                k      <= '0;
                fa_a   <= in_a[0];
                fa_b   <= in_b[0];
                fa_cin <= in_cin;
            end

            if (capture) begin
                out_sum[k] <= fa_sum;
                if (last_bit) begin
                    out_cout <= fa_cout;
                end else begin
                    k      <= k + 1'b1;
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    fa_a   <= a_q[1];
                    fa_b   <= b_q[1];
                    fa_cin <= fa_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: two instances (W=8/ADD_LAT=9 and
// W=4/ADD_LAT=1), each with its own pipelined full-adder model.

module tb_serial_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ---------------- W=8, ADD_LAT=9 instance and adder model
    logic       va8, rdy8, c8, fa8a, fa8b, fa8c, fs8, fc8, ov8, ry8, co8, busy8;
    logic [7:0] a8, b8, s8;

    serial_add_sequencer #(.W(8), .ADD_LAT(9)) dut8 (
        .clk(clk), .rst(rst), .in_valid(va8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8), .in_cin(c8),
        .fa_a(fa8a), .fa_b(fa8b), .fa_cin(fa8c), .fa_sum(fs8), .fa_cout(fc8),
        .out_valid(ov8), .out_ready(ry8), .out_sum(s8), .out_cout(co8), .busy(busy8)
    );

    logic [8:0] sp8 = '0;
    logic [8:0] cp8 = '0;
    always @(posedge clk) begin
        sp8 <= {sp8[7:0], fa8a ^ fa8b ^ fa8c};
        cp8 <= {cp8[7:0], (fa8a & fa8b) | (fa8a & fa8c) | (fa8b & fa8c)};
    end
    assign fs8 = sp8[8];
    assign fc8 = cp8[8];

    // ---------------- W=4, ADD_LAT=1 instance and adder model
    logic       va4, rdy4, c4, fa4a, fa4b, fa4c, fs4, fc4, ov4, ry4, co4, busy4;
    logic [3:0] a4, b4, s4;

    serial_add_sequencer #(.W(4), .ADD_LAT(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(va4), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .in_cin(c4),
        .fa_a(fa4a), .fa_b(fa4b), .fa_cin(fa4c), .fa_sum(fs4), .fa_cout(fc4),
        .out_valid(ov4), .out_ready(ry4), .out_sum(s4), .out_cout(co4), .busy(busy4)
    );

    logic sp4 = 1'b0;
    logic cp4 = 1'b0;
    always @(posedge clk) begin
        sp4 <= fa4a ^ fa4b ^ fa4c;
        cp4 <= (fa4a & fa4b) | (fa4a & fa4c) | (fa4b & fa4c);
    end
    assign fs4 = sp4;
    assign fc4 = cp4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        int         hold;
        bit         jitter;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One W=8 operation starting at the current negedge ("cycle 0").
    // It counts protocol deviations in bad: fa pulses at the wrong cycle or
    // with the wrong bits, ready/busy while working, and instability while
    // the result is held.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int hold, input bit jitter,
                       output logic [7:0] s, output logic co, output int lat, output int bad);
        int         t0, nn, j;
        logic [7:0] cin_exp;
        logic       cc;
        bad = 0; lat = -1; s = '0; co = 1'b0;
        cc = c;
        for (int i = 0; i < 8; i++) begin
            cin_exp[i] = cc;
            cc = (a[i] & b[i]) | (a[i] & cc) | (b[i] & cc);
        end
        for (int w = 0; w < 300 && rdy8 !== 1'b1; w++) @(negedge clk);
        if (rdy8 !== 1'b1) begin
            bad = 1;
            return;
        end
        va8 = 1'b1; a8 = a; b8 = b; c8 = c; ry8 = 1'b0; t0 = cyc;
        for (int n = 0; n < 200 && lat < 0; n++) begin
            @(negedge clk);
            nn = cyc - t0;
            if (jitter) begin
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            end else begin
                va8 = 1'b0;
            end
            if ((nn % 10 == 1) && (nn <= 71)) begin
                j = (nn - 1) / 10;
                if ({fa8a, fa8b, fa8c} !== {a[j], b[j], cin_exp[j]}) bad++;
            end else if ({fa8a, fa8b, fa8c} !== 3'b000) begin
                bad++;
            end
            if (ov8 === 1'b1) begin
                lat = nn; s = s8; co = co8;
            end else if (rdy8 !== 1'b0 || busy8 !== 1'b1) begin
                bad++;
            end
        end
        va8 = 1'b0;
        if (lat < 0) return;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (ov8 !== 1'b1 || s8 !== s || co8 !== co || rdy8 !== 1'b0 || busy8 !== 1'b1) bad++;
        end
        ry8 = 1'b1;
        @(negedge clk);
        ry8 = 1'b0;
        if (ov8 !== 1'b0 || rdy8 !== 1'b1 || busy8 !== 1'b0) bad++;
    endtask

    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input int hold, input bit jitter);
        logic [7:0] s;
        logic       co;
        int         lat, bad;
        op8(a, b, c, hold, jitter, s, co, lat, bad);
        chk({nm, "_sum"}, 32'(s), 32'(es));
        chk({nm, "_cout"}, 32'(co), 32'(ec));
        chk({nm, "_latency"}, 32'(lat), 32'd81);
        chk({nm, "_protocol_errors"}, 32'(bad), 32'd0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] e;
        int         t0, lat;
        lat = -1;
        e = {1'b0, a} + {1'b0, b} + 5'(c);
        for (int w = 0; w < 50 && rdy4 !== 1'b1; w++) @(negedge clk);
        va4 = 1'b1; a4 = a; b4 = b; c4 = c; ry4 = 1'b0; t0 = cyc;
        for (int n = 0; n < 50 && lat < 0; n++) begin
            @(negedge clk);
            va4 = 1'b0;
            if (ov4 === 1'b1) lat = cyc - t0;
        end
        chk("rnd4_sum", 32'(s4), 32'(e[3:0]));
        chk("rnd4_cout", 32'(co4), 32'(e[4]));
        chk("rnd4_latency", 32'(lat), 32'd9);
        ry4 = 1'b1;
        @(negedge clk);
        ry4 = 1'b0;
    endtask

    // Starts FF+01, pulses reset during cycle 'at', checks the cleared state,
    // then runs 01+01 while stale results are still draining from the model.
    task automatic reset_mid(input string nm, input int at);
        int t0;
        for (int w = 0; w < 300 && rdy8 !== 1'b1; w++) @(negedge clk);
        va8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; ry8 = 1'b0; t0 = cyc;
        @(negedge clk);
        va8 = 1'b0;
        for (int w = 0; w < 200 && (cyc - t0) < at; w++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, "_ctrl_after_rst"}, 32'({fa8a, fa8b, fa8c, ov8, co8, busy8, rdy8}), 32'h01);
        chk({nm, "_sum_after_rst"}, 32'(s8), 32'h00);
        run8({nm, "_next"}, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, hold: 0,  jitter: 1'b0};
        vecs[1] = '{a: 8'h5A, b: 8'h33, cin: 1'b1, sum: 8'h8E, cout: 1'b0, hold: 0,  jitter: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, hold: 0,  jitter: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, hold: 0,  jitter: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, hold: 0,  jitter: 1'b0};
        vecs[5] = '{a: 8'h0F, b: 8'hF0, cin: 1'b1, sum: 8'h00, cout: 1'b1, hold: 0,  jitter: 1'b0};
        vecs[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, sum: 8'hFF, cout: 1'b0, hold: 0,  jitter: 1'b0};
        vecs[7] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0, hold: 20, jitter: 1'b0};
        vecs[8] = '{a: 8'h5A, b: 8'h33, cin: 1'b1, sum: 8'h8E, cout: 1'b0, hold: 0,  jitter: 1'b1};

        rst = 1'b1;
        va8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; ry8 = 1'b0;
        va4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; ry4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl8", 32'({fa8a, fa8b, fa8c, ov8, co8, busy8, rdy8}), 32'h01);
        chk("reset_sum8", 32'(s8), 32'h00);
        chk("reset_ctrl4", 32'({fa4a, fa4b, fa4c, ov4, co4, busy4, rdy4}), 32'h01);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                 vecs[i].sum, vecs[i].cout, vecs[i].hold, vecs[i].jitter);

        reset_mid("rst40", 40);
        reset_mid("rst35", 35);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] e;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            e  = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            run8("rnd8", ra, rb, rc, e[7:0], e[8], 0, 1'b0);
        end

        for (int i = 0; i < 200; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001: The block SHALL have parameter W, default 8, giving the operand width in bits (legal range 2..32).
REQ-002: The block SHALL have parameter ADD_LAT, default 9, giving the clocked full-adder stage latency from input pulse to Sum/Carry_out in cycles (legal range >= 1).
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  1  operand request valid.
REQ-006: in_ready  output  1  block can accept an operand request.
REQ-007: in_a, in_b  input  W  operands, unsigned.
REQ-008: in_cin  input  1  initial carry-in.
REQ-009: fa_a, fa_b, fa_cin  output  1  registered bit pulses to the downstream full-adder stage A, B and Carry_in.
REQ-010: fa_sum, fa_cout  input  1  full-adder stage Sum and Carry_out, valid exactly ADD_LAT cycles after the corresponding fa_* pulse.
REQ-011: out_valid  output  1  result valid.
REQ-012: out_ready  input  1  consumer accepts the result.
REQ-013: out_sum  output  W  assembled sum; out_cout  output  1  final carry.
REQ-014: busy  output  1  high in every state except IDLE.

Function
REQ-015: The block SHALL implement states IDLE, ISSUE, WAIT and DONE.
REQ-016: In IDLE, in_ready SHALL be 1, and in_valid&in_ready SHALL latch in_a, in_b and in_cin, clear bit index k to 0, and move to ISSUE.
REQ-017: In ISSUE (one cycle), the block SHALL register fa_a=a[k], fa_b=b[k] and fa_cin=carry for exactly one cycle, then move to WAIT.
REQ-018: fa_a, fa_b and fa_cin SHALL be 0 in every cycle not driven by ISSUE.
REQ-019: In WAIT, a counter SHALL advance so that on the cycle exactly ADD_LAT cycles after the fa_* pulse, the block captures sum[k]=fa_sum and carry=fa_cout.
REQ-020: On that capture cycle, the block SHALL move to DONE if k==W-1, else increment k and move to ISSUE.
REQ-021: The bit period SHALL be ADD_LAT+1 cycles; with the accept at cycle 0, out_valid SHALL rise at cycle W*(ADD_LAT+1)+1 (81 for defaults).
REQ-022: fa_sum and fa_cout SHALL be ignored outside capture cycles.
REQ-023: In DONE, out_valid SHALL be 1 and out_sum/out_cout SHALL remain stable until out_valid&out_ready, then the block SHALL return to IDLE.
REQ-024: in_ready SHALL be 0 in DONE; a new request SHALL be accepted no earlier than the cycle after the result handshake.
REQ-025: in_valid SHALL be ignored while busy, and in_a/in_b/in_cin changes after accept SHALL not affect the result.
REQ-026: out_sum bit k SHALL be written only on its capture cycle; W-bit wrap-around SHALL be reported solely via out_cout.

Reset
REQ-027: With rst high at a clock edge, state SHALL become IDLE and k, counter, out_sum, out_cout, out_valid, fa_a, fa_b, fa_cin and busy SHALL become 0, while in_ready SHALL be 1 from the next cycle.
REQ-028: Reset SHALL take priority over all handshakes, including mid-operation.
REQ-029: Results of in-flight adder pulses returning after reset SHALL be ignored.

Verification
REQ-030: The bench SHALL provide a full-adder model with ADD_LAT=9 and cover in_a=8'hFF, in_b=8'h01, cin=0 -> out_sum=8'h00 and out_cout=1, with out_valid first high exactly 81 cycles after accept.
REQ-031: The bench SHALL cover in_a=8'h5A, in_b=8'h33, cin=1 -> out_sum=8'h8E and out_cout=0, with fa_* pulses at cycles 1, 11, ..., 71 only.
REQ-032: The bench SHALL cover out_ready held 0 for 20 cycles after out_valid -> out_sum/out_cout stable and in_ready=0 throughout, then IDLE one cycle after the handshake.
REQ-033: The bench SHALL cover rst pulsed for 1 cycle at cycle 40 of an operation -> all outputs 0 next cycle, in_ready=1, and a following 8'h01+8'h01 producing 8'h02 despite stale fa_sum pulses.
REQ-034: The bench SHALL cover in_valid held high with changing in_a while busy -> only the first request is processed and its result is correct.
REQ-035: The bench SHALL cover 200 random back-to-back operand pairs for W=8 and W=4/ADD_LAT=1 -> every result matches (a+b+cin).
